vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised successor of the fixed 800x480 VGA sync generator. It produces HS, VS and BLANK with any timing, polarity and pipeline alignment. It issues pixel coordinates ahead of time to an external pixel source. It also muxes the output between that source and three built-in test patterns (grid, colour bars, solid). It drives the video DAC / LCD output stage directly on the pixel clock.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP / HPULSE / HBP, 40 / 48 / 40, horizontal front porch / sync / back porch in pixels
VFP / VPULSE / VBP, 13 / 3 / 29, vertical front porch / sync / back porch in lines
HS_POL / VS_POL, 0 / 0, active level of HS / VS pulse
PIPE_LAT, 2, cycles from pixel_x/pixel_y/pixel_req to valid ext_rgb (range 0..8)
GRID, 16, grid pitch in pixels for mode 1

Ports:
pixel_clk  in  1  pixel clock
pixel_rst_n  in  1  asynchronous, active-low reset
mode  in  2  0 external, 1 grid, 2 colour bars, 3 solid grey
ext_rgb  in  24  external pixel {R,G,B}, valid PIPE_LAT cycles after the matching pixel_req
pixel_x  out  clog2(HDISP)  active-area column, stage 0
pixel_y  out  clog2(VDISP)  active-area row, stage 0
pixel_req  out  1  high when pixel_x/pixel_y name an active pixel
frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0 (stage 0)
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_blank  out  1  1 = active video (DAC BLANK_n convention)
vga_rgb  out  24  pixel colour

Behaviour:
- Counters: h_cnt runs 0..HTOTAL-1, where HTOTAL = HFP+HPULSE+HBP+HDISP; it wraps to 0.
- v_cnt increments on h_cnt wrap and runs 0..VTOTAL-1, where VTOTAL = VFP+VPULSE+VBP+VDISP; it wraps to 0 when both counters are at their maximum.
- Line order: front porch, sync, back porch, active. Active means h_cnt >= HFP+HPULSE+HBP and v_cnt >= VFP+VPULSE+VBP.
- Stage 0 (combinational from counters):
  - pixel_req = active.
  - pixel_x = h_cnt-(HFP+HPULSE+HBP) and pixel_y = v_cnt-(VFP+VPULSE+VBP) when active; both are 0 otherwise.
  - hs_raw is active while HFP <= h_cnt < HFP+HPULSE.
  - vs_raw is active while VFP <= v_cnt < VFP+VPULSE.
- Alignment: hs_raw, vs_raw, active, pixel_x and pixel_y pass through a PIPE_LAT-deep shift register, then one output register.
  - Total latency from counter state to vga_* outputs is PIPE_LAT+1 cycles.
  - ext_rgb is captured in the same output register, so it lines up with its coordinates.
- Sync polarity: vga_hs = HS_POL while hs_raw is active, else ~HS_POL. vga_vs uses VS_POL in the same way.
- Mode latch: mode is sampled into mode_q only on the cycle frame_start is high. A mid-frame change takes effect at the next frame, with no tearing. mode_q resets to 0.
- RGB, computed from the delayed coordinates:
  - active=0: 24'h000000 (explicitly cleared every cycle).
  - mode 0: ext_rgb.
  - mode 1: 24'hFFFFFF if x%GRID==0 or y%GRID==0, else 24'h000000.
  - mode 2: 8 vertical bars of width HDISP/8, ordered white, yellow, cyan, green, magenta, red, blue, black. Any remainder pixels at the right edge are black.
  - mode 3: 24'h808080.
- Reset (async assert, sync release):
  - counters = 0; shift register cleared to the inactive state.
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL, vga_blank = 0, vga_rgb = 0, mode_q = 0.
  - After release, the first cycle is h_cnt=0, v_cnt=0 and frame_start=1.
  - Reset mid-frame restarts timing from frame 0; no partial sync pulse is extended.
- Widths: counters are clog2(HTOTAL) and clog2(VTOTAL) bits. The modulo may be implemented with wrapping sub-counters; the result must be identical.

Test Plan:
1. Defaults, run 2 frames. Required: HS period 928 cycles, low for 48; VS period 928*525 cycles, low for 3 lines; vga_blank high 800 cycles per line on 480 lines; frame_start period 487200.
2. Model ext_rgb = {pixel_x[7:0], pixel_y[7:0], 8'h5A} delayed by 2 cycles, mode 0. Required: at the first active output, vga_rgb = 24'h00005A, 3 cycles after pixel_req first rises; at x=799, y=479, vga_rgb = 24'h1FDF5A.
3. Mode 1, GRID=16. Required: x=0,16,32 white on every row; row y=5, x=5 black; every blanking cycle black.
4. Mode 2. Required: x=0..99 white, x=100..199 24'hFFFF00, x=700..799 black.
5. Switch mode 0→3 mid-frame. Required: no change until the next frame_start; from the next frame's first active pixel, vga_rgb = 24'h808080.
6. Assert pixel_rst_n low mid-line with HS_POL=1. Required: vga_hs=0, vga_blank=0, vga_rgb=0 immediately, with no clock needed; frame_start=1 on the first cycle after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD timing generator with a look-ahead pixel request and a
// built-in test-pattern mux. Release of pixel_rst_n must be synchronous to pixel_clk.
module vga_timing_gen #(
  parameter int HDISP    = 800,
  parameter int VDISP    = 480,
  parameter int HFP      = 40,
  parameter int HPULSE   = 48,
  parameter int HBP      = 40,
  parameter int VFP      = 13,
  parameter int VPULSE   = 3,
  parameter int VBP      = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 2,
  parameter int GRID     = 16,
  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1,
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst_n,
  input  logic [1:0]    mode,
  input  logic [23:0]   ext_rgb,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          pixel_req,
  output logic          frame_start,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank,
  output logic [23:0]   vga_rgb
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int BARW   = (HDISP / 8 > 0) ? HDISP / 8 : 1;
  localparam int BW     = 5 + XW + YW;
  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HW-1:0] h_off;
  logic [VW-1:0] v_off;
  logic          active, hs_raw, vs_raw;
  logic [1:0]    mode_q, mode_cur;
  logic [BW-1:0] stage0, dly;
  logic          hs_d, vs_d, active_d;
  logic [1:0]    mode_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic [23:0]   rgb_next;
  int            bar;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(HTOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(VTOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active      = (h_cnt >= HW'(HSTART)) && (v_cnt >= VW'(VSTART));
  assign h_off       = h_cnt - HW'(HSTART);
  assign v_off       = v_cnt - VW'(VSTART);
  assign pixel_x     = active ? h_off[XW-1:0] : '0;
  assign pixel_y     = active ? v_off[YW-1:0] : '0;
  assign pixel_req   = active;
  assign hs_raw      = (h_cnt >= HW'(HFP)) && (h_cnt < HW'(HFP + HPULSE));
  assign vs_raw      = (v_cnt >= VW'(VFP)) && (v_cnt < VW'(VFP + VPULSE));
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

  // The mode travels with each pixel, so the tail of the old frame still in
  // the pipe keeps the old mode while the new frame picks up the latched one.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n)     mode_q <= 2'd0;
    else if (frame_start) mode_q <= mode;
  end

  assign mode_cur = frame_start ? mode : mode_q;
  assign stage0   = {hs_raw, vs_raw, active, mode_cur, pixel_x, pixel_y};

  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign dly = stage0;
    end else begin : g_pipe
      logic [BW-1:0] sr [PIPE_LAT];
      always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
          for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
        end else begin
          sr[0] <= stage0;
          for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
        end
      end
      assign dly = sr[PIPE_LAT-1];
    end
  endgenerate

  assign {hs_d, vs_d, active_d, mode_d, x_d, y_d} = dly;

  always_comb begin
    rgb_next = 24'h000000;
    bar      = 0;
    if (active_d) begin
      case (mode_d)
        2'd0: rgb_next = ext_rgb;
        2'd1: if ((int'(x_d) % GRID == 0) || (int'(y_d) % GRID == 0)) rgb_next = 24'hFFFFFF;
        2'd2: begin
          bar = int'(x_d) / BARW;
          if (bar < 8) rgb_next = BAR_RGB[bar[2:0]];
        end
        default: rgb_next = 24'h808080;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      vga_hs    <= ~HS_POL;
      vga_vs    <= ~VS_POL;
      vga_blank <= 1'b0;
      vga_rgb   <= 24'h000000;
    end else begin
      vga_hs    <= hs_d ? HS_POL : ~HS_POL;
      vga_vs    <= vs_d ? VS_POL : ~VS_POL;
      vga_blank <= active_d;
      vga_rgb   <= rgb_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster: every cycle is compared with a
// frame-arithmetic model, plus directed pattern, mode-switch and reset checks.
module tb_vga_timing_gen;

  localparam int HDISP = 44, VDISP = 24;
  localparam int HFP = 4, HPULSE = 3, HBP = 5;
  localparam int VFP = 2, VPULSE = 2, VBP = 3;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
  localparam int PIPE_LAT = 2, GRID = 8;
  localparam int XW = $clog2(HDISP), YW = $clog2(VDISP);
  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int FRAME  = HTOTAL * VTOTAL;

  logic          pixel_clk = 1'b0;
  logic          pixel_rst_n;
  logic [1:0]    mode;
  logic [23:0]   ext_rgb;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          pixel_req, frame_start, vga_hs, vga_vs, vga_blank;
  logic [23:0]   vga_rgb;

  vga_timing_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(HS_POL), .VS_POL(VS_POL),
    .PIPE_LAT(PIPE_LAT), .GRID(GRID)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .mode(mode), .ext_rgb(ext_rgb),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_req(pixel_req), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank), .vga_rgb(vga_rgb)
  );

  initial forever #5 pixel_clk = ~pixel_clk;

  int         checks = 0;
  int         failures = 0;
  int         t = 0;
  bit         rand_mode = 1'b0;
  int         frame_mode [16];
  bit         req_h [PIPE_LAT+1];
  logic [7:0] xh [PIPE_LAT+1];
  logic [7:0] yh [PIPE_LAT+1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    assert (obs === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, expected, t);
    end
  endtask

  // Pattern colours from the rules: bars use R on for bar%4<2, G for bar<4, B for even bars.
  function automatic logic [23:0] model_rgb(input int m, input int x, input int y);
    logic [7:0] xb, yb;
    int b;
    xb = 8'(x);
    yb = 8'(y);
    case (m)
      0: return {xb, yb, 8'h5A};
      1: return ((x % GRID == 0) || (y % GRID == 0)) ? 24'hFFFFFF : 24'h000000;
      2: begin
        b = x / (HDISP / 8);
        if (b >= 8) return 24'h000000;
        return {((b % 4) < 2) ? 8'hFF : 8'h00, (b < 4) ? 8'hFF : 8'h00, (b % 2 == 0) ? 8'hFF : 8'h00};
      end
      default: return 24'h808080;
    endcase
  endfunction

  // Output state at cycle tt reflects the raster position PIPE_LAT+1 cycles earlier.
  task automatic model_out(input int tt, output bit hs, output bit vs, output bit act, output logic [23:0] rgb);
    int s, pos, h, v;
    s = tt - PIPE_LAT - 1;
    hs = 0; vs = 0; act = 0; rgb = 24'h0;
    if (s >= 0) begin
      pos = s % FRAME;
      h   = pos % HTOTAL;
      v   = pos / HTOTAL;
      act = (h >= HSTART) && (v >= VSTART);
      hs  = (h >= HFP) && (h < HFP + HPULSE);
      vs  = (v >= VFP) && (v < VFP + VPULSE);
      if (act) rgb = model_rgb(frame_mode[s / FRAME], h - HSTART, v - VSTART);
    end
  endtask

  task automatic sample_and_check();
    int pos, h, v;
    bit act, ohs, ovs, oact;
    logic [23:0] orgb;
    pos = t % FRAME;
    h   = pos % HTOTAL;
    v   = pos / HTOTAL;
    act = (h >= HSTART) && (v >= VSTART);
    check("pixel_req", 32'(pixel_req), 32'(act));
    check("pixel_x", 32'(pixel_x), act ? 32'(h - HSTART) : 32'd0);
    check("pixel_y", 32'(pixel_y), act ? 32'(v - VSTART) : 32'd0);
    check("frame_start", 32'(frame_start), 32'(pos == 0));
    model_out(t, ohs, ovs, oact, orgb);
    check("vga_hs", 32'(vga_hs), 32'(ohs ? HS_POL : !HS_POL));
    check("vga_vs", 32'(vga_vs), 32'(ovs ? VS_POL : !VS_POL));
    check("vga_blank", 32'(vga_blank), 32'(oact));
    check("vga_rgb", 32'(vga_rgb), 32'(orgb));
    // External pixel source: answers each request PIPE_LAT cycles later, junk otherwise.
    for (int i = PIPE_LAT; i > 0; i--) begin
      req_h[i] = req_h[i-1];
      xh[i]    = xh[i-1];
      yh[i]    = yh[i-1];
    end
    req_h[0] = pixel_req;
    xh[0]    = 8'(pixel_x);
    yh[0]    = 8'(pixel_y);
    ext_rgb  = req_h[PIPE_LAT] ? {xh[PIPE_LAT], yh[PIPE_LAT], 8'h5A} : 24'($urandom());
  endtask

  task automatic apply_stimulus();
    if (rand_mode && ($urandom_range(0, 299) == 0)) mode = 2'($urandom_range(0, 3));
    if ((t % FRAME == 0) && (t / FRAME < 16)) frame_mode[t / FRAME] = int'(mode);
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
    t++;
    apply_stimulus();
    sample_and_check();
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  function automatic int t_of(input int f, input int x, input int y);
    return f * FRAME + (VSTART + y) * HTOTAL + HSTART + x + PIPE_LAT + 1;
  endfunction

  // Called at the release edge: restart the model at raster position 0.
  task automatic start_frames(input logic [1:0] m);
    t = 0;
    mode = m;
    for (int i = 0; i < 16; i++) frame_mode[i] = 0;
    for (int i = 0; i <= PIPE_LAT; i++) begin
      req_h[i] = 0; xh[i] = 8'h0; yh[i] = 8'h0;
    end
    frame_mode[0] = int'(mode);
    #1;
    sample_and_check();
  endtask

  // Reset asserted between clock edges; outputs must drop without a clock.
  task automatic reset_now(input logic [1:0] next_mode);
    #2;
    pixel_rst_n = 1'b0;
    #1;
    check("rst_async_hs", 32'(vga_hs), 32'(!HS_POL));
    check("rst_async_vs", 32'(vga_vs), 32'(!VS_POL));
    check("rst_async_blank", 32'(vga_blank), 32'd0);
    check("rst_async_rgb", 32'(vga_rgb), 32'd0);
    check("rst_async_req", 32'(pixel_req), 32'd0);
    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_hold_hs", 32'(vga_hs), 32'(!HS_POL));
    check("rst_hold_frame_start", 32'(frame_start), 32'd1);
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;
    start_frames(next_mode);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found, ohs, ovs, oact;
    logic [23:0] orgb;
    pixel_rst_n = 1'b1;
    mode        = 2'd0;
    ext_rgb     = 24'h0;
    #1 pixel_rst_n = 1'b0;
    #1;
    check("reset_hs", 32'(vga_hs), 32'(!HS_POL));
    check("reset_vs", 32'(vga_vs), 32'(!VS_POL));
    check("reset_blank", 32'(vga_blank), 32'd0);
    check("reset_rgb", 32'(vga_rgb), 32'd0);
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;
    start_frames(2'd0);

    $display("[TB] frame 0 external source, mode 3 requested mid-frame");
    run_to(t_of(0, 0, 0) - 1);
    check("first_active_blank_before", 32'(vga_blank), 32'd0);
    run_to(t_of(0, 0, 0));
    check("first_active_blank", 32'(vga_blank), 32'd1);
    check("first_active_rgb", 32'(vga_rgb), 32'h00005A);
    run_to(FRAME / 2);
    mode = 2'd3;
    run_to(t_of(0, 43, 23));
    check("last_pixel_rgb", 32'(vga_rgb), 32'h2B175A);
    run_to(t_of(1, 0, 0));
    check("mode3_first_pixel", 32'(vga_rgb), 32'h808080);

    $display("[TB] grid frame then colour bars frame");
    run_to(FRAME + FRAME / 2);
    mode = 2'd1;
    run_to(t_of(2, 0, 0));
    check("grid_x0_y0", 32'(vga_rgb), 32'hFFFFFF);
    run_to(t_of(2, 5, 0));
    check("grid_x5_y0", 32'(vga_rgb), 32'hFFFFFF);
    run_to(t_of(2, 16, 3));
    check("grid_x16_y3", 32'(vga_rgb), 32'hFFFFFF);
    run_to(t_of(2, 5, 5));
    check("grid_x5_y5", 32'(vga_rgb), 32'h000000);
    run_to(2 * FRAME + FRAME / 2);
    mode = 2'd2;
    run_to(t_of(3, 5, 0));
    check("bars_yellow", 32'(vga_rgb), 32'hFFFF00);
    run_to(t_of(3, 30, 0));
    check("bars_blue", 32'(vga_rgb), 32'h0000FF);
    run_to(t_of(3, 40, 10));
    check("bars_remainder", 32'(vga_rgb), 32'h000000);

    $display("[TB] random mode changes");
    rand_mode = 1'b1;
    run_to(7 * FRAME);
    rand_mode = 1'b0;

    $display("[TB] reset during horizontal sync pulse");
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      model_out(t, ohs, ovs, oact, orgb);
      if (ohs) begin found = 1; break; end
      step();
    end
    check("wait_hs_pulse", 32'(found), 32'd1);
    check("hs_before_reset", 32'(vga_hs), 32'(HS_POL));
    reset_now(2'd3);

    $display("[TB] reset during active video");
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      model_out(t, ohs, ovs, oact, orgb);
      if (oact && (t % HTOTAL == 20)) begin found = 1; break; end
      step();
    end
    check("wait_active", 32'(found), 32'd1);
    reset_now(2'd0);
    run_to(FRAME + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
